// File: rtl/button_conditioner_pkg.sv
// Shared definitions for the push-button conditioner: FSM encoding and
// default timing for a 50 MHz clock.
package button_conditioner_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        HOLD   = 2'd1,
        REPEAT = 2'd2
    } btn_state_t;

    localparam int DEF_DEBOUNCE_CYCLES = 500000;
    localparam int DEF_REPEAT_DELAY    = 25000000;
    localparam int DEF_REPEAT_PERIOD   = 5000000;
    localparam int DEF_CNT_W           = 25;

    localparam int NUM_BTN = 2;

endpackage

// File: rtl/button_conditioner_if.sv
// Raw button inputs and conditioned step pulses as one bundle.
interface button_conditioner_if;
    logic plus_raw;
    logic minus_raw;
    logic plus;
    logic minus;

    modport master (output plus_raw, output minus_raw, input plus, input minus);
    modport slave  (input plus_raw, input minus_raw, output plus, output minus);
endinterface

// File: rtl/button_conditioner_channel.sv
// One button: 2-flop synchronizer, debouncer, and press/auto-repeat FSM
// producing a registered single-cycle pulse.
module button_channel
    import button_conditioner_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
    parameter int REPEAT_DELAY    = DEF_REPEAT_DELAY,
    parameter int REPEAT_PERIOD   = DEF_REPEAT_PERIOD,
    parameter int CNT_W           = DEF_CNT_W
) (
    input  logic clk,
    input  logic rst,
    input  logic raw,
    output logic pulse
);

    localparam logic [CNT_W-1:0] DB_LAST  = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [CNT_W-1:0] DLY_LAST = CNT_W'(REPEAT_DELAY - 1);
    localparam logic [CNT_W-1:0] PER_LAST = CNT_W'(REPEAT_PERIOD - 1);

    // sync[0] is the metastability catcher; only sync[1] feeds logic
    logic [1:0]       sync;
    logic             s2;
    logic             level;
    logic [CNT_W-1:0] dcnt;

    btn_state_t       state, state_n;
    logic [CNT_W-1:0] tcnt, tcnt_n;
    logic             p, p_n;

    assign s2 = sync[1];

    always_ff @(posedge clk) begin
        if (rst) begin
            sync  <= '0;
            level <= 1'b0;
            dcnt  <= '0;
        end else begin
            sync <= {sync[0], raw};
            if (s2 == level) begin
                dcnt <= '0;
            end else if (dcnt == DB_LAST) begin
                level <= s2;
                dcnt  <= '0;
            end else begin
                dcnt <= dcnt + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            tcnt  <= '0;
            p     <= 1'b0;
        end else begin
            state <= state_n;
            tcnt  <= tcnt_n;
            p     <= p_n;
        end
    end

    // Release is tested first so a coincident timer expiry emits nothing
    always_comb begin
        state_n = state;
        tcnt_n  = tcnt;
        p_n     = 1'b0;
        case (state)
            IDLE: begin
                if (level) begin
                    state_n = HOLD;
                    tcnt_n  = '0;
                    p_n     = 1'b1;
                end
            end
            HOLD: begin
                if (!level) begin
                    state_n = IDLE;
                end else if (tcnt == DLY_LAST) begin
                    state_n = REPEAT;
                    tcnt_n  = '0;
                    p_n     = 1'b1;
                end else begin
                    tcnt_n = tcnt + 1'b1;
                end
            end
            REPEAT: begin
                if (!level) begin
                    state_n = IDLE;
                end else if (tcnt == PER_LAST) begin
                    tcnt_n = '0;
                    p_n    = 1'b1;
                end else begin
                    tcnt_n = tcnt + 1'b1;
                end
            end
            default: begin
                state_n = IDLE;
                tcnt_n  = '0;
            end
        endcase
    end

    assign pulse = p;

endmodule

// File: rtl/button_conditioner.sv
// Conditions the plus/minus push-buttons into clean step pulses for the
// up/down counter; coincident pulses cancel.
module button_conditioner
    import button_conditioner_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
    parameter int REPEAT_DELAY    = DEF_REPEAT_DELAY,
    parameter int REPEAT_PERIOD   = DEF_REPEAT_PERIOD,
    parameter int CNT_W           = DEF_CNT_W
) (
    input  logic                  clk,
    input  logic                  rst,
    button_conditioner_if.slave   bus
);

    // Index 0 is plus, index 1 is minus
    logic [NUM_BTN-1:0] raw;
    logic [NUM_BTN-1:0] p;

    assign raw = {bus.minus_raw, bus.plus_raw};

    for (genvar i = 0; i < NUM_BTN; i++) begin : g_ch
        button_channel #(
            .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
            .REPEAT_DELAY    (REPEAT_DELAY),
            .REPEAT_PERIOD   (REPEAT_PERIOD),
            .CNT_W           (CNT_W)
        ) u_ch (
            .clk   (clk),
            .rst   (rst),
            .raw   (raw[i]),
            .pulse (p[i])
        );
    end

    assign bus.plus  = p[0] & ~p[1];
    assign bus.minus = p[1] & ~p[0];

endmodule

// File: tb/tb_button_conditioner.sv
// Scoreboard bench: stimulus queues expected pulse cycles, a negedge monitor
// matches every observed pulse and flags missing or extra ones.
module tb_button_conditioner;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   cyc = 0;
    int   errors = 0;
    int   checks = 0;
    bit   mon_en = 1'b0;

    typedef struct {
        int cyc;
        bit up;
    } exp_t;

    exp_t q[$];
    exp_t e;

    button_conditioner_if bif ();

    button_conditioner #(
        .DEBOUNCE_CYCLES (4),
        .REPEAT_DELAY    (20),
        .REPEAT_PERIOD   (8),
        .CNT_W           (5)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bif.slave)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (mon_en) begin
            while (q.size() > 0 && q[0].cyc < cyc) begin
                checks++;
                errors++;
                $display("FAIL missed_pulse: got none by cycle %0d, required %s pulse at cycle %0d",
                         cyc, q[0].up ? "plus" : "minus", q[0].cyc);
                void'(q.pop_front());
            end
            if (bif.plus || bif.minus) begin
                checks++;
                if (q.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_pulse: got plus=%0b minus=%0b at cycle %0d, required none",
                             bif.plus, bif.minus, cyc);
                end else begin
                    e = q.pop_front();
                    if (e.cyc != cyc || bif.plus != e.up || bif.plus == bif.minus) begin
                        errors++;
                        $display("FAIL pulse_match: got plus=%0b minus=%0b at cycle %0d, required %s at cycle %0d",
                                 bif.plus, bif.minus, cyc, e.up ? "plus" : "minus", e.cyc);
                    end
                end
            end
        end
    end

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic expect_pulse(input int c, input bit up);
        exp_t x;
        x.cyc = c;
        x.up  = up;
        q.push_back(x);
    endtask

    task automatic check_drained(input string name);
        checks++;
        if (q.size() != 0) begin
            errors++;
            $display("FAIL %s_drained: got %0d pending pulses, required 0", name, q.size());
            q.delete();
        end
    endtask

    int base;

    initial begin
        bif.plus_raw  = 1'b0;
        bif.minus_raw = 1'b0;
        rst = 1'b1;
        step(3);
        checks++;
        if (bif.plus !== 1'b0 || bif.minus !== 1'b0) begin
            errors++;
            $display("FAIL reset_outputs: got plus=%b minus=%b, required 0 0", bif.plus, bif.minus);
        end
        rst = 1'b0;
        mon_en = 1'b1;
        step(2);

        // clean press, no pulse on release
        bif.plus_raw = 1'b1;
        base = cyc + 1;
        expect_pulse(base + 6, 1'b1);
        step(15);
        bif.plus_raw = 1'b0;
        step(20);
        check_drained("clean_press");

        // bounce, then stable high
        bif.plus_raw = 1'b1; step(2);
        bif.plus_raw = 1'b0; step(1);
        bif.plus_raw = 1'b1; step(3);
        bif.plus_raw = 1'b0; step(2);
        bif.plus_raw = 1'b1;
        base = cyc + 1;
        expect_pulse(base + 6, 1'b1);
        step(15);
        bif.plus_raw = 1'b0;
        step(20);
        check_drained("bounce");

        // 3-cycle glitch is filtered
        bif.plus_raw = 1'b1; step(3);
        bif.plus_raw = 1'b0; step(20);
        check_drained("glitch");

        // auto-repeat; the slot at 66 falls after release is accepted
        bif.plus_raw = 1'b1;
        base = cyc + 1;
        expect_pulse(base + 6, 1'b1);
        expect_pulse(base + 26, 1'b1);
        expect_pulse(base + 34, 1'b1);
        expect_pulse(base + 42, 1'b1);
        expect_pulse(base + 50, 1'b1);
        expect_pulse(base + 58, 1'b1);
        step(60);
        bif.plus_raw = 1'b0;
        step(30);
        check_drained("auto_repeat");

        // simultaneous press cancels
        bif.plus_raw  = 1'b1;
        bif.minus_raw = 1'b1;
        step(15);
        bif.plus_raw  = 1'b0;
        bif.minus_raw = 1'b0;
        step(20);
        check_drained("simultaneous");

        // staggered press passes both
        bif.plus_raw = 1'b1;
        base = cyc + 1;
        expect_pulse(base + 6, 1'b1);
        expect_pulse(base + 8, 1'b0);
        step(2);
        bif.minus_raw = 1'b1;
        step(15);
        bif.plus_raw  = 1'b0;
        bif.minus_raw = 1'b0;
        step(20);
        check_drained("staggered");

        // reset sampled at edge 15 while in HOLD
        bif.plus_raw = 1'b1;
        base = cyc + 1;
        expect_pulse(base + 6, 1'b1);
        step(15);
        rst = 1'b1;
        step(1);
        checks++;
        if (bif.plus !== 1'b0 || bif.minus !== 1'b0) begin
            errors++;
            $display("FAIL mid_reset_outputs: got plus=%b minus=%b, required 0 0", bif.plus, bif.minus);
        end
        rst = 1'b0;
        expect_pulse(base + 22, 1'b1);
        step(10);
        bif.plus_raw = 1'b0;
        step(20);
        check_drained("reset_mid_hold");

        mon_en = 1'b0;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
